// File: rtl/clk_tick_sched.sv
// Decade tick-enable chain with a runtime-selectable strobe output.
// All timing derives from clk_50MHz as enables; no derived clocks.
module clk_tick_sched #(
    parameter int unsigned RATIO_1    = 5,
    parameter int unsigned RATIO_2    = 10,
    parameter int unsigned RESET_RATE = 7
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic       run,
    input  logic       sync_clr,
    input  logic       rate_req,
    input  logic [2:0] rate_sel,
    output logic       rate_ack,
    output logic [2:0] cur_rate,
    output logic [7:0] tick,
    output logic       sel_tick,
    output logic       sel_sq
);

    localparam int unsigned NSTAGE = 8;
    localparam int unsigned RW     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t            r_state;
    logic [RW-1:0]     r_pend;
    logic [RW-1:0]     r_cur_rate;
    logic              r_sel_sq;

    logic              w_adv0;
    logic [NSTAGE-1:0] w_tc;
    logic [NSTAGE-1:0] w_tick;
    logic [RW-1:0]     w_sel_idx;
    logic              w_sel_tick;
    logic              w_pend_hit;

    assign w_adv0 = run & ~sync_clr;

    // One counter per stage; each advances on the previous stage's tick.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int unsigned RATIO = (k == 1) ? RATIO_1 : RATIO_2;
        localparam int unsigned CW    = $clog2(RATIO);

        logic [CW-1:0] r_cnt;
        logic          w_adv;

        if (k == 0) begin : g_first
            assign w_adv = w_adv0;
        end else begin : g_next
            assign w_adv = w_tick[k-1];
        end

        assign w_tc[k] = (r_cnt == CW'(RATIO - 1));

        always_ff @(posedge clk_50MHz or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (sync_clr) begin
                r_cnt <= '0;
            end else if (w_adv) begin
                r_cnt <= w_tc[k] ? '0 : r_cnt + CW'(1);
            end
        end
    end

    // Tick k fires when stage 0 advances and stages 0..k are all at terminal count.
    always_comb begin : p_tick
        logic v_acc;
        w_tick = '0;
        v_acc  = w_adv0;
        for (int k = 0; k < NSTAGE; k++) begin
            v_acc     = v_acc & w_tc[k];
            w_tick[k] = v_acc;
        end
    end

    // While waiting, the selected strobe follows the pending rate only.
    assign w_sel_idx  = (r_state == ST_WAIT) ? r_pend : r_cur_rate;
    assign w_sel_tick = w_tick[w_sel_idx];
    assign w_pend_hit = (r_state == ST_WAIT) & w_tick[r_pend];

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pend     <= '0;
            r_cur_rate <= RW'(RESET_RATE);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rate_req) begin
                        if (rate_sel == r_cur_rate) begin
                            r_state <= ST_ACK;
                        end else begin
                            r_pend  <= rate_sel;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_tick[r_pend]) begin
                        r_cur_rate <= r_pend;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_sq <= 1'b0;
        end else if (sync_clr) begin
            r_sel_sq <= 1'b0;
        end else if (w_sel_tick) begin
            r_sel_sq <= ~r_sel_sq;
        end
    end

    assign rate_ack = (r_state == ST_ACK) | w_pend_hit;
    assign cur_rate = r_cur_rate;
    assign tick     = w_tick;
    assign sel_tick = w_sel_tick;
    assign sel_sq   = r_sel_sq;

endmodule

// File: tb/tb_clk_tick_sched.sv
// Directed bench for clk_tick_sched: default ratios on dut_a, ratio 2/2 chain on dut_b.
module tb_clk_tick_sched;

    logic       clk_50MHz = 1'b0;
    logic       rst_n;
    logic       run;
    logic       sync_clr;
    logic       rate_req;
    logic [2:0] rate_sel;
    logic       rate_req_b;
    logic [2:0] rate_sel_b;

    logic       rate_ack_a, sel_tick_a, sel_sq_a;
    logic [2:0] cur_rate_a;
    logic [7:0] tick_a;
    logic       rate_ack_b, sel_tick_b, sel_sq_b;
    logic [2:0] cur_rate_b;
    logic [7:0] tick_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk_50MHz = ~clk_50MHz;

    clk_tick_sched #(.RATIO_1(5), .RATIO_2(10), .RESET_RATE(7)) dut_a (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .run       (run),
        .sync_clr  (sync_clr),
        .rate_req  (rate_req),
        .rate_sel  (rate_sel),
        .rate_ack  (rate_ack_a),
        .cur_rate  (cur_rate_a),
        .tick      (tick_a),
        .sel_tick  (sel_tick_a),
        .sel_sq    (sel_sq_a)
    );

    clk_tick_sched #(.RATIO_1(2), .RATIO_2(2), .RESET_RATE(7)) dut_b (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .run       (run),
        .sync_clr  (sync_clr),
        .rate_req  (rate_req_b),
        .rate_sel  (rate_sel_b),
        .rate_ack  (rate_ack_b),
        .cur_rate  (cur_rate_b),
        .tick      (tick_b),
        .sel_tick  (sel_tick_b),
        .sel_sq    (sel_sq_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50MHz);
        #1;
        cyc++;
    endtask

    initial begin
        logic [7:0] exp_t;
        rst_n      = 1'b0;
        run        = 1'b1;
        sync_clr   = 1'b0;
        rate_req   = 1'b0;
        rate_sel   = 3'd0;
        rate_req_b = 1'b0;
        rate_sel_b = 3'd0;

        repeat (3) @(posedge clk_50MHz);
        #2;
        check("rst_tick_a", 32'(tick_a), 32'h0);
        check("rst_cur_a", 32'(cur_rate_a), 32'd7);
        check("rst_ack_a", 32'(rate_ack_a), 32'd0);
        check("rst_sel_a", 32'(sel_tick_a), 32'd0);
        check("rst_sq_a", 32'(sel_sq_a), 32'd0);
        check("rst_tick_b", 32'(tick_b), 32'h0);

        // Release mid-cycle: the cycle ending at the next edge is cycle 1.
        @(negedge clk_50MHz);
        rst_n = 1'b1;
        cyc   = 1;

        // Free-running chains on both instances.
        while (cyc < 520) begin
            step();
            #1;
            exp_t = '0;
            exp_t[0] = (cyc % 10 == 0);
            exp_t[1] = (cyc % 50 == 0);
            exp_t[2] = (cyc % 500 == 0);
            check("a_tick", 32'(tick_a), 32'(exp_t));
            check("a_sel_tick", 32'(sel_tick_a), 32'd0);
            for (int k = 0; k < 8; k++) exp_t[k] = (cyc % (2 << k) == 0);
            check("b_tick", 32'(tick_b), 32'(exp_t));
            check("b_sel_tick", 32'(sel_tick_b), 32'(exp_t[7]));
            check("b_sel_sq", 32'(sel_sq_b), 32'(((cyc - 1) / 256) % 2));
        end

        // Request rate 0 while at rate 7: switch on next tick[0] (cycle 530).
        while (cyc < 530) begin
            step();
            rate_req = 1'b1;
            rate_sel = 3'd0;
            #1;
            check("sw_ack", 32'(rate_ack_a), 32'(cyc == 530));
            check("sw_sel_tick", 32'(sel_tick_a), 32'(cyc == 530));
            check("sw_cur", 32'(cur_rate_a), 32'd7);
            if (rate_ack_a) rate_req = 1'b0;
        end
        while (cyc < 560) begin
            step();
            #1;
            check("new_cur", 32'(cur_rate_a), 32'd0);
            check("new_ack", 32'(rate_ack_a), 32'd0);
            check("new_sel_tick", 32'(sel_tick_a), 32'(cyc % 10 == 0));
            check("new_sel_sq", 32'(sel_sq_a), 32'((((cyc - 531) / 10) % 2) == 0));
        end

        // Same-rate request: ack one cycle after the request is sampled.
        while (cyc < 570) begin
            step();
            if (cyc == 561) begin
                rate_req = 1'b1;
                rate_sel = 3'd0;
            end
            #1;
            check("same_ack", 32'(rate_ack_a), 32'(cyc == 562));
            check("same_sel_tick", 32'(sel_tick_a), 32'(cyc % 10 == 0));
            check("same_cur", 32'(cur_rate_a), 32'd0);
            if (rate_ack_a) rate_req = 1'b0;
        end

        // run low for cycles 573..579 shifts ticks by 7.
        while (cyc < 600) begin
            step();
            run = !(cyc >= 573 && cyc <= 579);
            #1;
            if (cyc < 573)       exp_t[0] = (cyc % 10 == 0);
            else if (cyc <= 579) exp_t[0] = 1'b0;
            else                 exp_t[0] = ((cyc - 7) % 10 == 0);
            check("run_tick0", 32'(tick_a[0]), 32'(exp_t[0]));
            check("run_sel_tick", 32'(sel_tick_a), 32'(exp_t[0]));
        end
        run = 1'b1;

        // sync_clr in the tick cycle 607; next tick 10 cycles later.
        while (cyc < 620) begin
            step();
            sync_clr = (cyc == 607);
            #1;
            check("clr_tick0", 32'(tick_a[0]), 32'(cyc == 617));
            if (cyc == 607) begin
                check("clr_all_ticks", 32'(tick_a), 32'h0);
                check("clr_sq_before", 32'(sel_sq_a), 32'd1);
                check("clr_cur", 32'(cur_rate_a), 32'd0);
            end
            if (cyc == 608) check("clr_sq_after", 32'(sel_sq_a), 32'd0);
        end
        sync_clr = 1'b0;

        // Reset asserted while waiting for rate 3.
        step();
        rate_req = 1'b1;
        rate_sel = 3'd3;
        #1;
        check("wr_ack0", 32'(rate_ack_a), 32'd0);
        step();
        #1;
        check("wr_ack1", 32'(rate_ack_a), 32'd0);
        check("wr_cur1", 32'(cur_rate_a), 32'd0);
        step();
        rst_n    = 1'b0;
        rate_req = 1'b0;
        #1;
        check("wr_rst_ack", 32'(rate_ack_a), 32'd0);
        check("wr_rst_cur", 32'(cur_rate_a), 32'd7);
        check("wr_rst_tick", 32'(tick_a), 32'h0);
        check("wr_rst_sel", 32'(sel_tick_a), 32'd0);
        check("wr_rst_sq", 32'(sel_sq_a), 32'd0);
        @(negedge clk_50MHz);
        rst_n = 1'b1;
        cyc   = 1;
        while (cyc < 12) begin
            step();
            #1;
            check("post_tick0", 32'(tick_a[0]), 32'(cyc == 10));
            check("post_ack", 32'(rate_ack_a), 32'd0);
            check("post_cur", 32'(cur_rate_a), 32'd7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
